lustre_signed_ge_seq: RTL and testbench

- Multi-cycle signed greater-or-equal comparator: res = (lhs >= rhs), two's complement, N bits.
- Computes the complement of the combinational signed less-than block: ge = not lt.
- Walks operands MSB-first, D bits per cycle, so wide compares in area-constrained nodes need no N-bit carry chain.
- Valid/ready on input and output; drops into stream pipelines generated for Lustre comparison nodes.

---
 rtl/lustre_signed_ge_seq.sv | 146 ++++++++++++++
 tb/tb_lustre_signed_ge_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/lustre_signed_ge_seq.sv
// lustre_signed_ge_seq: multi-cycle signed (lhs >= rhs) comparator, MSB-first, D bits per cycle.
// Optional build macro LUSTRE_SIGNED_GE_EARLY_EXIT_EN: finish on the first differing digit.
`default_nettype none

module lustre_signed_ge_seq #(
    parameter int N = 8,
    parameter int D = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] lhs,
    input  logic [N-1:0] rhs,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         res
);

    localparam int K  = (N + D - 1) / D;
    localparam int P  = K * D;
    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam logic [CW-1:0] LAST = CW'(K - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [P-1:0]  a_sh;
    logic [P-1:0]  b_sh;
    logic [CW-1:0] count;
    logic          decided;
    logic          gt;

    logic [N-1:0]  lhs_adj;
    logic [N-1:0]  rhs_adj;
    logic [P-1:0]  a_load;
    logic [P-1:0]  b_load;
    logic [D-1:0]  a_dig;
    logic [D-1:0]  b_dig;
    logic          differ;
    logic          dig_gt;
    logic          gt_now;
    logic          last_digit;
    logic          finish;
    logic          accept;
    logic          handoff;

    // Flipping the sign bit turns two's complement order into unsigned order.
    always_comb begin
        lhs_adj        = lhs;
        rhs_adj        = rhs;
        lhs_adj[N-1]   = ~lhs[N-1];
        rhs_adj[N-1]   = ~rhs[N-1];
        a_load         = P'(lhs_adj) << (P - N);
        b_load         = P'(rhs_adj) << (P - N);
    end

    assign a_dig      = a_sh[P-1 -: D];
    assign b_dig      = b_sh[P-1 -: D];
    assign differ     = (a_dig != b_dig);
    assign dig_gt     = (a_dig > b_dig);
    assign last_digit = (count == LAST);

    // Verdict as of this digit: an earlier decision wins, full equality means ge.
    always_comb begin
        gt_now = 1'b1;
        if (decided) begin
            gt_now = gt;
        end else if (differ) begin
            gt_now = dig_gt;
        end
    end

`ifdef LUSTRE_SIGNED_GE_EARLY_EXIT_EN
    assign finish = last_digit | (~decided & differ);
`else
    assign finish = last_digit;
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign handoff   = out_valid & out_ready;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)  state_next = RUN;
            RUN:     if (finish)  state_next = DONE;
            DONE:    if (handoff) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            count   <= '0;
            decided <= 1'b0;
            gt      <= 1'b0;
            res     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sh    <= a_load;
                        b_sh    <= b_load;
                        count   <= '0;
                        decided <= 1'b0;
                        gt      <= 1'b0;
                    end
                end
                RUN: begin
                    if (!decided && differ) begin
                        decided <= 1'b1;
                        gt      <= dig_gt;
                    end
                    a_sh  <= a_sh << D;
                    b_sh  <= b_sh << D;
                    count <= count + 1'b1;
                    if (finish) begin
                        res <= gt_now;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_lustre_signed_ge_seq.sv
// Directed self-checking bench for lustre_signed_ge_seq at (N,D) = (8,2), (5,2), (8,1).
`default_nettype none

module tb_lustre_signed_ge_seq;

`ifdef LUSTRE_SIGNED_GE_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] lhs = 8'h00;
    logic [7:0] rhs = 8'h00;
    logic       out_ready = 1'b1;
    logic [2:0] in_valid = 3'b000;
    logic [2:0] in_ready;
    logic [2:0] out_valid;
    logic [2:0] res;

    int checks = 0;
    int failures = 0;
    int cur = 0;

    always #5 clock = ~clock;

    lustre_signed_ge_seq #(.N(8), .D(2)) u_8d2 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .lhs(lhs), .rhs(rhs),
        .out_valid(out_valid[0]), .out_ready(out_ready), .res(res[0])
    );

    lustre_signed_ge_seq #(.N(5), .D(2)) u_5d2 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .lhs(lhs[4:0]), .rhs(rhs[4:0]),
        .out_valid(out_valid[1]), .out_ready(out_ready), .res(res[1])
    );

    lustre_signed_ge_seq #(.N(8), .D(1)) u_8d1 (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .lhs(lhs), .rhs(rhs),
        .out_valid(out_valid[2]), .out_ready(out_ready), .res(res[2])
    );

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // One transaction on DUT `sel`; `hold` cycles of out_ready=0 once the result is up.
    task automatic do_cmp(input int sel, input logic [7:0] l, input logic [7:0] r,
                          input int exp_res, input int exp_lat, input int hold,
                          input string tag);
        int lat;
        cur = sel;
        check({tag, "_ready"}, int'(in_ready[sel]), 1);
        lhs = l;
        rhs = r;
        out_ready = (hold == 0);
        in_valid[sel] = 1'b1;
        step();
        in_valid[sel] = 1'b0;
        lhs = ~l;
        rhs = ~r;
        lat = 0;
        while (!out_valid[sel] && lat < 40) begin
            step();
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_res"}, int'(res[sel]), exp_res);
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_valid"}, int'(out_valid[sel]), 1);
            check({tag, "_hold_res"}, int'(res[sel]), exp_res);
            check({tag, "_hold_ready"}, int'(in_ready[sel]), 0);
        end
        out_ready = 1'b1;
        step();
        check({tag, "_post_valid"}, int'(out_valid[sel]), 0);
        check({tag, "_post_ready"}, int'(in_ready[sel]), 1);
    endtask

    initial begin
        #2;
        check("rst_in_ready", int'(in_ready), 7);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_res", int'(res), 0);
        step();
        reset_n = 1'b1;
        step();

        do_cmp(0, 8'hFF, 8'h00, 0, EE ? 1 : 4, 0, "m1_vs_0");
        do_cmp(0, 8'h7F, 8'h80, 1, EE ? 1 : 4, 0, "p127_vs_m128");
        do_cmp(0, 8'h55, 8'h55, 1, 4, 0, "eq55");
        do_cmp(1, 8'h10, 8'h11, 0, 3, 0, "n5_m16_vs_m15");
        do_cmp(1, 8'h11, 8'h10, 1, 3, 0, "n5_m15_vs_m16");
        do_cmp(0, 8'h03, 8'h02, 1, 4, 5, "bp_3_vs_2");

        // Abort a D=1 compare in its second RUN cycle.
        lhs = 8'h12;
        rhs = 8'h34;
        in_valid[2] = 1'b1;
        step();
        in_valid[2] = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        check("abort_out_valid", int'(out_valid[2]), 0);
        check("abort_in_ready", int'(in_ready[2]), 1);
        step();
        reset_n = 1'b1;
        step();
        check("abort_idle_valid", int'(out_valid[2]), 0);

        do_cmp(2, 8'hFD, 8'hFD, 1, 8, 0, "m3_vs_m3");
        do_cmp(2, 8'h80, 8'h00, 0, EE ? 1 : 8, 0, "d1_m128_vs_0");
        do_cmp(2, 8'h01, 8'h00, 1, 8, 0, "d1_1_vs_0");
        do_cmp(2, 8'h80, 8'h7F, 0, EE ? 1 : 8, 0, "d1_m128_vs_127");
        do_cmp(2, 8'hFE, 8'hFF, 0, 8, 0, "d1_m2_vs_m1");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
